// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access, with data
// priority, a fetch anti-starvation override, and a per-access ack timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STARVE_LIM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_IF,
  output logic        stall_MEM,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIM);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] starve_cnt;
  logic       busy;
  logic       grant_d;
  logic       grant_f;
  logic       ack_done;
  logic       abort;

  // A pending fetch that has already lost STARVE_LIM data grants in a row wins the next slot.
  always_comb begin
    grant_d  = d_req & ~(if_req & (starve_cnt == STARVE_MAX));
    grant_f  = if_req & ~grant_d;
    busy     = (state == S_FETCH) || (state == S_DATA);
    ack_done = busy & mem_ack;
    abort    = busy & ~mem_ack & (wait_cnt == WAIT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (grant_d)      state_nxt = S_DATA;
        else if (grant_f) state_nxt = S_FETCH;
      end
      S_FETCH, S_DATA: state_nxt = (ack_done || abort) ? S_IDLE : state;
      default:         state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state != S_IDLE);
    stall_IF  = if_req & ~if_valid;
    stall_MEM = d_req & ~d_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      if_rdata    <= '0;
      if_valid    <= 1'b0;
      d_rdata     <= '0;
      d_valid     <= 1'b0;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (state == S_IDLE) begin
        wait_cnt <= '0;
        if (grant_d) begin
          mem_we     <= d_we;
          mem_addr   <= d_addr;
          mem_wdata  <= d_wdata;
          mem_wmask  <= d_wmask;
          starve_cnt <= if_req ? ((starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 8'd1)
                               : 8'd0;
        end else if (grant_f) begin
          mem_we     <= 1'b0;
          mem_addr   <= if_addr;
          mem_wdata  <= '0;
          mem_wmask  <= '0;
          starve_cnt <= '0;
        end
      end else if (busy) begin
        if (ack_done) begin
          if (state == S_FETCH) begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end else begin
            d_valid <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end else if (abort) begin
          timeout_err <= 1'b1;
          if (state == S_FETCH) begin
            if_valid <= 1'b1;
            if_rdata <= '0;
          end else begin
            d_valid <= 1'b1;
            d_rdata <= '0;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted access waits for mem_ack; range 1..255, 8-bit counter.
REQ-002 Parameter STARVE_LIM, default 2: max consecutive data grants while a fetch is pending.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req  in  1  fetch request; held with if_addr until if_valid.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetched word; valid when if_valid, held until next fetch completes.
REQ-008 if_valid  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request; held with d_* until d_valid.
REQ-010 d_we  in  1  1 = write, 0 = read.
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_wmask  in  4  byte write mask.
REQ-014 d_rdata  out  32  read data; valid when d_valid on a read; held until next read completes.
REQ-015 d_valid  out  1  one-cycle data completion pulse.
REQ-016 mem_req  out  1  request to shared memory; high for the whole granted access.
REQ-017 mem_we, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched request fields; mem_we/mem_wmask forced 0 for fetches.
REQ-018 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-019 mem_ack  in  1  memory completion, one cycle per access.
REQ-020 stall_IF  out  1  = if_req & ~if_valid; holds PC/IF-ID.
REQ-021 stall_MEM  out  1  = d_req & ~d_valid; freezes whole pipeline.
REQ-022 timeout_err  out  1  sticky timeout flag.

Function
REQ-023 States IDLE, FETCH, DATA; 2-bit state register; unused encodings SHALL go to IDLE next cycle.
REQ-024 IDLE: d_req -> DATA; else if_req -> FETCH; else stay; fields latched on the grant edge.
REQ-025 Priority override: if if_req and d_req both high and starve_cnt == STARVE_LIM, grant FETCH.
REQ-026 starve_cnt: +1 on each data grant with if_req high, saturating at STARVE_LIM; cleared on every fetch grant and whenever a data grant occurs with if_req low.
REQ-027 mem_req = (state != IDLE); mem_* fields driven only from latched registers, stable for the whole access.
REQ-028 FETCH/DATA: on mem_ack high, capture mem_rdata (reads only), pulse matching valid next cycle, return to IDLE.
REQ-029 Latency: grant edge N, mem_req high cycle N+1; ack at cycle N+k gives valid at cycle N+k+1 (min 2 cycles request-to-valid).
REQ-030 No back-to-back grant: one IDLE cycle between accesses; new request evaluated in that IDLE cycle.
REQ-031 Write completes identically; d_rdata unchanged on writes.
REQ-032 Requester input changes after grant are ignored; deasserted req mid-access still completes, valid pulses, result discarded by requester.
REQ-033 mem_ack in IDLE ignored.
REQ-034 Timeout: wait counter clears on grant, +1 per busy cycle without ack; reaching TIMEOUT aborts access, sets timeout_err, pulses matching valid with rdata 0, returns IDLE.
REQ-035 Ack and timeout in same cycle: ack wins, no error.

Reset
REQ-036 rst high SHALL immediately force state IDLE, mem_req 0, all mem_* 0, if_valid 0, d_valid 0, if_rdata 0, d_rdata 0, counters 0, timeout_err 0.
REQ-037 Reset mid-access abandons the access; no valid pulse follows; first grant evaluated on first edge after rst falls.

Verification
REQ-038 Fetch only: if_req=1, addr 0x100, ack after 3 cycles with 0x00500093 -> if_valid one pulse, if_rdata=0x00500093, stall_IF low after.
REQ-039 Simultaneous if_req and d_req (read 0x2000) -> DATA first, then FETCH; mem_addr 0x2000 then fetch address.
REQ-040 d_req continuously with three queued data ops and if_req held -> grant order D,D,F,D (STARVE_LIM=2).
REQ-041 Write d_addr 0x3000, wdata 0xDEADBEEF, mask 0xF -> mem_we=1, fields stable until ack, d_rdata unchanged.
REQ-042 No ack for 255 busy cycles -> abort, d_valid pulse with d_rdata=0, timeout_err=1 until rst.
REQ-043 rst asserted mid-DATA -> mem_req drops same cycle, no d_valid, next request granted normally.
